// File: rtl/daa_result_reader.sv
// daa_result_reader
// Reads one DAA result snapshot over the byte-multiplexed o_in bus.
// sel steps through bytes 0..3 and each byte gets SETTLE+1 cycles to settle.
// freeze_n stays low for the whole read, so the DAA holds a coherent value.
// The reassembled fields are loaded together on the byte-3 capture edge.
// They hold until the next byte-3 capture, even while a new read is running.
// Optional feature: define DAA_RD_FRAME_CHECK_EN to flag a set bit 7 in byte 3 on err.
module daa_result_reader #(
   parameter int SETTLE = 1            // settle cycles per byte, legal 0..3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  o_in,
   output logic [1:0]  sel,
   output logic        freeze_n,
   output logic        busy,
   output logic        valid,
   input  logic        ready,
   output logic [9:0]  result,
   output logic [17:0] e_result,
   output logic [2:0]  exp_result,
   output logic        err
);

   localparam logic [1:0] SETTLE_CNT = 2'(SETTLE);

   typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       settled;
   logic       cap;
   logic [7:0] b0, b1, b2;

   assign settled = (cnt == SETTLE_CNT);

   // State and settle counter; reset aborts any capture in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, settle count, capture strobe and Moore outputs
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cap       = 1'b0;
      sel       = 2'd0;
      freeze_n  = 1'b1;
      busy      = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = PH0;
               cnt_nxt   = 2'd0;
            end
         end
         PH0: begin
            sel      = 2'd0;
            freeze_n = 1'b0;
            busy     = 1'b1;
            if (settled) begin
               cap       = 1'b1;
               state_nxt = PH1;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         PH1: begin
            sel      = 2'd1;
            freeze_n = 1'b0;
            busy     = 1'b1;
            if (settled) begin
               cap       = 1'b1;
               state_nxt = PH2;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         PH2: begin
            sel      = 2'd2;
            freeze_n = 1'b0;
            busy     = 1'b1;
            if (settled) begin
               cap       = 1'b1;
               state_nxt = PH3;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         PH3: begin
            sel      = 2'd3;
            freeze_n = 1'b0;
            busy     = 1'b1;
            if (settled) begin
               cap       = 1'b1;
               state_nxt = DONE;
               cnt_nxt   = 2'd0;
            end else begin
               cnt_nxt = cnt + 2'd1;
            end
         end
         DONE: begin
            valid = 1'b1;
            // A start in the same cycle as ready chains straight into the next read
            if (ready) begin
               state_nxt = start ? PH0 : IDLE;
               cnt_nxt   = 2'd0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
         end
      endcase
   end

   // Byte capture: bytes 0..2 are staged; byte 3 commits the whole snapshot at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         b0         <= 8'd0;
         b1         <= 8'd0;
         b2         <= 8'd0;
         result     <= 10'd0;
         e_result   <= 18'd0;
         exp_result <= 3'd0;
      end else if (cap) begin
         case (state)
            PH0: b0 <= o_in;
            PH1: b1 <= o_in;
            PH2: b2 <= o_in;
            PH3: begin
               result     <= {o_in[6:5], b0};
               e_result   <= {o_in[4:0], b2, b1[7:3]};
               exp_result <= b1[2:0];
            end
            default: ;
         endcase
      end
   end

`ifdef DAA_RD_FRAME_CHECK_EN
   // Framing check: bit 7 of byte 3 carries no data and must read back as 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err <= 1'b0;
      else if (cap && state == PH3)
         err <= o_in[7];
   end
`else
   // Bit 7 of byte 3 carries no data, so nothing reads it without the check
   logic unused_frame_bit;
   assign unused_frame_bit = o_in[7];
   assign err = 1'b0;
`endif

endmodule
